// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the IF-stage program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_BRANCH = 2'd1,
        CAUSE_EXC    = 2'd2
    } cause_e;

    localparam logic [31:0] DEFAULT_RESET_VEC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC     = 32'h0000_0008;
    localparam int          DEFAULT_INSTR_BYTES = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer holding a redirect that arrived while the pipeline was stalled.
// An exception always replaces a buffered branch; a branch never displaces an exception.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            capture_exc_i,
    input  logic [XLEN-1:0] exc_target_i,
    input  logic            capture_br_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic            pending_o,
    output logic [XLEN-1:0] target_o
);

    logic            valid_q,  valid_d;
    cause_e          cause_q,  cause_d;
    logic [XLEN-1:0] target_q, target_d;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d  = valid_q;
        cause_d  = cause_q;
        target_d = target_q;
        if (clear_i) begin
            valid_d = 1'b0;
            cause_d = CAUSE_NONE;
        end else if (capture_exc_i) begin
            valid_d  = 1'b1;
            cause_d  = CAUSE_EXC;
            target_d = exc_target_i;
        end else if (capture_br_i && (cause_q != CAUSE_EXC)) begin
            valid_d  = 1'b1;
            cause_d  = CAUSE_BRANCH;
            target_d = br_target_i;
        end
    end

    // NOTE: state registers use non-blocking assignments; the target is reset too so it never reads as X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            cause_q  <= CAUSE_NONE;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    assign pending_o = valid_q;
    assign target_o  = target_q;

endmodule

// File: rtl/pc_gen.sv
// IF-stage PC generator: BOOT/RUN/HALT control, next-PC priority mux and stall-time redirect buffering.
// Optional stall-cycle counter is built when PC_GEN_STALL_CNT_EN is defined; otherwise stall_cycles_o is 0.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEFAULT_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC     = XLEN'(DEFAULT_EXC_VEC),
    parameter int              INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_redirect_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            exc_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic            fetch_valid_o,
    output logic            redirect_pending_o,
    output logic [31:0]     stall_cycles_o
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));
    localparam logic [XLEN-1:0] EXC_TARGET = EXC_VEC & ALIGN_MASK;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            buf_clear, buf_cap_exc, buf_cap_br;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] br_target_aligned;

    assign br_target_aligned = br_target_i & ALIGN_MASK;

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (buf_clear),
        .capture_exc_i (buf_cap_exc),
        .exc_target_i  (EXC_TARGET),
        .capture_br_i  (buf_cap_br),
        .br_target_i   (br_target_aligned),
        .pending_o     (pend_valid),
        .target_o      (pend_target)
    );

    // A halt is only honoured on a sequential step: any redirect in the same cycle flushes it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_clear   = 1'b0;
        buf_cap_exc = 1'b0;
        buf_cap_br  = 1'b0;
        case (state_q)
            BOOT: begin
                state_d     = RUN;
                buf_cap_exc = exc_i;
            end
            RUN: begin
                if (stall_i) begin
                    buf_cap_exc = exc_i;
                    buf_cap_br  = br_redirect_i;
                end else if (exc_i) begin
                    pc_d      = EXC_TARGET;
                    buf_clear = 1'b1;
                end else if (pend_valid) begin
                    pc_d      = pend_target;
                    buf_clear = 1'b1;
                end else if (br_redirect_i) begin
                    pc_d = br_target_aligned;
                end else if (halt_i) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + STEP;
                end
            end
            HALT: begin
                if (exc_i) begin
                    state_d = RUN;
                    pc_d    = EXC_TARGET;
                end else if (resume_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o               = pc_q;
    assign fetch_valid_o      = (state_q == RUN);
    assign redirect_pending_o = pend_valid;

`ifdef PC_GEN_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == RUN) && stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a behavioural model.
// A 32-bit and an 8-bit instance share stimulus; the 8-bit PC must equal the model PC modulo 256.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, br = 1'b0, exc = 1'b0, halt = 1'b0, resume = 1'b0;
    logic [31:0] tgt = '0;

    logic [31:0] pc32;
    logic        fv32, pend32;
    logic [31:0] cnt32;
    logic [7:0]  pc8;
    logic        fv8, pend8;
    logic [31:0] cnt8;

    pc_gen #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .stall_i(stall), .br_redirect_i(br), .br_target_i(tgt),
        .exc_i(exc), .halt_i(halt), .resume_i(resume),
        .pc_o(pc32), .fetch_valid_o(fv32), .redirect_pending_o(pend32), .stall_cycles_o(cnt32)
    );

    pc_gen #(.XLEN(8), .RESET_VEC(8'h00), .EXC_VEC(8'h08), .INSTR_BYTES(4)) dut8 (
        .clk(clk), .rst(rst), .stall_i(stall), .br_redirect_i(br), .br_target_i(tgt[7:0]),
        .exc_i(exc), .halt_i(halt), .resume_i(resume),
        .pc_o(pc8), .fetch_valid_o(fv8), .redirect_pending_o(pend8), .stall_cycles_o(cnt8)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, PC and at most one remembered redirect.
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_has_pend, m_pend_exc;
    logic [31:0] m_pend_pc;
    logic [31:0] m_stalls;
    bit          cmp_en = 1'b0;

    function automatic logic [31:0] exp_cnt();
`ifdef PC_GEN_STALL_CNT_EN
        return m_stalls;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_mode     = M_BOOT;
        m_pc       = 32'h0;
        m_has_pend = 0;
        m_pend_exc = 0;
        m_pend_pc  = 32'h0;
        m_stalls   = 32'h0;
    endtask

    // Applies one rising edge with the inputs that were present before it.
    task automatic model_step();
        logic [31:0] t;
        t = tgt & 32'hFFFF_FFFC;
        if (m_mode == M_BOOT) begin
            if (exc) begin
                m_has_pend = 1; m_pend_exc = 1; m_pend_pc = 32'h8;
            end
            m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (exc) begin
                m_mode = M_RUN; m_pc = 32'h8;
            end else if (resume) begin
                m_mode = M_RUN;
            end
        end else if (stall) begin
            if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (exc) begin
                m_has_pend = 1; m_pend_exc = 1; m_pend_pc = 32'h8;
            end else if (br && !(m_has_pend && m_pend_exc)) begin
                m_has_pend = 1; m_pend_exc = 0; m_pend_pc = t;
            end
        end else if (exc) begin
            m_pc = 32'h8; m_has_pend = 0;
        end else if (m_has_pend) begin
            m_pc = m_pend_pc; m_has_pend = 0;
        end else if (br) begin
            m_pc = t;
        end else if (halt) begin
            m_mode = M_HALT;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock cycle with the given inputs; returns 1 ns after the rising edge.
    task automatic cycle(input bit s, input bit b, input logic [31:0] t, input bit e,
                         input bit h, input bit r);
        stall = s; br = b; tgt = t; exc = e; halt = h; resume = r;
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic idle(); cycle(0, 0, 32'h0, 0, 0, 0); endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc32",   pc32,   m_pc);
            check("fv32",   fv32,   (m_mode == M_RUN));
            check("pend32", pend32, m_has_pend);
            check("cnt32",  cnt32,  exp_cnt());
            check("pc8",    pc8,    m_pc[7:0]);
            check("fv8",    fv8,    (m_mode == M_RUN));
            check("pend8",  pend8,  m_has_pend);
            check("cnt8",   cnt8,   exp_cnt());
        end
    end

    initial begin
        model_reset();
        #12;
        check("reset_pc", pc32, 32'h0);
        check("reset_fv", fv32, 1'b0);
        check("reset_pend", pend32, 1'b0);
        check("reset_cnt", cnt32, 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("boot_fv", fv32, 1'b0);

        idle(); check("step0", pc32, 32'h0); check("run_fv", fv32, 1'b1);
        idle(); check("step4", pc32, 32'h4);
        idle(); check("step8", pc32, 32'h8);
        idle(); idle(); check("at10", pc32, 32'h10);

        for (int i = 0; i < 3; i++) cycle(1, 0, 32'h0, 0, 0, 0);
        check("stall_hold", pc32, 32'h10);
        idle(); check("after_stall", pc32, 32'h14);
`ifdef PC_GEN_STALL_CNT_EN
        check("stall_cnt", cnt32, 32'd3);
`else
        check("stall_cnt", cnt32, 32'd0);
`endif

        cycle(1, 1, 32'h103, 0, 0, 0);
        check("br_pend", pend32, 1'b1);
        idle();
        check("br_release", pc32, 32'h100);
        check("br_cleared", pend32, 1'b0);

        cycle(1, 1, 32'h200, 0, 0, 0);
        cycle(1, 0, 32'h0, 1, 0, 0);
        cycle(1, 1, 32'h300, 0, 0, 0);
        idle();
        check("exc_over_br", pc32, 32'h8);
        check("exc_cleared", pend32, 1'b0);

        cycle(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        check("top32", pc32, 32'hFFFF_FFFC);
        check("top8", pc8, 8'hFC);
        idle();
        check("wrap32", pc32, 32'h0);
        check("wrap8", pc8, 8'h00);

        cycle(0, 0, 32'h0, 0, 1, 0);
        check("halt_fv", fv32, 1'b0); check("halt_pc", pc32, 32'h0);
        idle(); check("halt_hold", pc32, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 1);
        check("resume_fv", fv32, 1'b1); check("resume_pc", pc32, 32'h0);
        idle(); check("resume_step", pc32, 32'h4);
        cycle(0, 0, 32'h0, 0, 1, 0);
        cycle(0, 0, 32'h0, 1, 0, 1);
        check("halt_exc", pc32, 32'h8); check("halt_exc_fv", fv32, 1'b1);

        cycle(1, 1, 32'h40, 0, 0, 0);
        check("pre_rst_pend", pend32, 1'b1);
        rst = 1'b1; model_reset(); #1;
        check("mid_rst_pc", pc32, 32'h0);
        check("mid_rst_pend", pend32, 1'b0);
        check("mid_rst_fv", fv32, 1'b0);
        cycle(0, 0, 32'h0, 0, 0, 0);
        rst = 1'b0;

        // Boot-time exception lands on the first RUN edge.
        cycle(0, 0, 32'h0, 1, 0, 0);
        check("boot_exc_pend", pend32, 1'b1);
        idle();
        check("boot_exc_pc", pc32, 32'h8);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; model_reset();
                idle();
                rst = 1'b0;
            end else begin
                cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom(),
                      $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 4) == 0);
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
